// File: rtl/serializer_fsm_pkg.sv
// Shared FIR stream constants: word width common to the serializer, deserializer and FIR.
package serializer_fsm_pkg;

    localparam int unsigned FIR_STREAM_LENGTH = 24;

endpackage

// File: rtl/serializer_fsm.sv
// Parallel-to-serial converter for the FIR output path: LSB-first bit stream with a
// one-word holding buffer so consecutive words stream without an idle bit.
module serializer_fsm
    import serializer_fsm_pkg::*;
#(
    parameter int unsigned LENGTH = FIR_STREAM_LENGTH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [LENGTH-1:0] iv_din,
    input  logic              i_din_valid,
    output logic              o_ready,
    output logic              o_dout,
    output logic              o_dout_valid,
    input  logic              i_ready,
    output logic              o_last,
    output logic              o_busy
);

    localparam int unsigned CNT_W = $clog2(LENGTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b01,
        ST_SHIFT = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [LENGTH-1:0]   buf_q, buf_d;
    logic                buf_valid_q, buf_valid_d;
    logic [LENGTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;

    logic accept_c;
    logic xfer_c;
    logic final_bit_c;

    assign accept_c    = i_en && i_din_valid && ready_q;
    assign xfer_c      = i_en && dout_valid_q && i_ready;
    assign final_bit_c = (cnt_q == CNT_W'(LENGTH - 1));

    // Next-state: every output is computed one edge ahead so it can be registered.
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        buf_valid_d  = buf_valid_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        ready_d      = ready_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        last_d       = last_q;
        busy_d       = busy_q;

        if (i_en) begin
            // ready_q implies the buffer is empty, so accept never collides with a drain.
            if (accept_c) begin
                buf_d       = iv_din;
                buf_valid_d = 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (buf_valid_q) begin
                        state_d      = ST_SHIFT;
                        shift_d      = buf_q;
                        cnt_d        = '0;
                        buf_valid_d  = 1'b0;
                        dout_d       = buf_q[0];
                        dout_valid_d = 1'b1;
                        last_d       = 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (xfer_c) begin
                        if (!final_bit_c) begin
                            shift_d = shift_q >> 1;
                            cnt_d   = cnt_q + CNT_W'(1);
                            dout_d  = shift_q[1];
                            last_d  = (cnt_q == CNT_W'(LENGTH - 2));
                        end else if (buf_valid_q) begin
                            shift_d     = buf_q;
                            cnt_d       = '0;
                            buf_valid_d = 1'b0;
                            dout_d      = buf_q[0];
                            last_d      = 1'b0;
                        end else begin
                            state_d      = ST_IDLE;
                            cnt_d        = '0;
                            dout_d       = 1'b0;
                            dout_valid_d = 1'b0;
                            last_d       = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d      = ST_IDLE;
                    cnt_d        = '0;
                    dout_d       = 1'b0;
                    dout_valid_d = 1'b0;
                    last_d       = 1'b0;
                end
            endcase

            ready_d = !buf_valid_d;
            busy_d  = buf_valid_d || (state_d == ST_SHIFT);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            buf_q        <= '0;
            buf_valid_q  <= 1'b0;
            shift_q      <= '0;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            buf_valid_q  <= buf_valid_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_dout       = dout_q;
    assign o_dout_valid = dout_valid_q;
    assign o_last       = last_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_serializer_fsm.sv
// Self-checking bench for serializer_fsm: directed scenarios plus a random loopback,
// all checked against a word/bit-queue model with a behavioural deserializer.
module tb_serializer_fsm;
    import serializer_fsm_pkg::*;

    localparam int unsigned L = FIR_STREAM_LENGTH;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_en;
    logic [L-1:0] iv_din;
    logic         i_din_valid;
    logic         o_ready;
    logic         o_dout;
    logic         o_dout_valid;
    logic         i_ready;
    logic         o_last;
    logic         o_busy;

    always #5 i_clk = ~i_clk;

    serializer_fsm #(.LENGTH(L)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .iv_din      (iv_din),
        .i_din_valid (i_din_valid),
        .o_ready     (o_ready),
        .o_dout      (o_dout),
        .o_dout_valid(o_dout_valid),
        .i_ready     (i_ready),
        .o_last      (o_last),
        .o_busy      (o_busy)
    );

    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;

    // Model: words accepted (in order) and the LSB-first bits still owed downstream.
    logic [L-1:0] src_q[$];
    bit           exp_bits[$];
    int unsigned  bit_pos = 0;
    logic [L-1:0] deser = '0;
    int unsigned  n_words_out = 0;
    bit           model_live = 1'b0;
    bit           last_acc = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check state, drive inputs, account for the handshakes the next edge performs.
    task automatic cycle(input logic en, input logic dv, input logic [L-1:0] din,
                         input logic rdy, input logic rst);
        if (model_live) begin
            check_eq("busy", 32'(o_busy), 32'(exp_bits.size() != 0));
            if (exp_bits.size() == 0)
                check_eq("idle_valid", 32'(o_dout_valid), 32'd0);
        end
        i_rst       = rst;
        i_en        = en;
        i_din_valid = dv;
        iv_din      = din;
        i_ready     = rdy;
        last_acc    = 1'b0;
        if (rst) begin
            src_q.delete();
            exp_bits.delete();
            bit_pos = 0;
        end else if (en) begin
            if (o_dout_valid && rdy) begin
                if (exp_bits.size() == 0) begin
                    check_eq("spurious_bit", 32'(o_dout_valid), 32'd0);
                end else begin
                    check_eq("dout", 32'(o_dout), 32'(exp_bits.pop_front()));
                    check_eq("last", 32'(o_last), 32'(bit_pos == L - 1));
                    deser[bit_pos] = o_dout;
                    if (bit_pos == L - 1) begin
                        check_eq("word", 32'(deser), 32'(src_q.pop_front()));
                        n_words_out++;
                        bit_pos = 0;
                    end else begin
                        bit_pos++;
                    end
                end
            end
            if (dv && o_ready) begin
                src_q.push_back(din);
                for (int i = 0; i < int'(L); i++) exp_bits.push_back(din[i]);
                last_acc = 1'b1;
            end
        end
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(o_ready), 32'd0);
        check_eq({tag, "_dout"}, 32'(o_dout), 32'd0);
        check_eq({tag, "_valid"}, 32'(o_dout_valid), 32'd0);
        check_eq({tag, "_last"}, 32'(o_last), 32'd0);
        check_eq({tag, "_busy"}, 32'(o_busy), 32'd0);
    endtask

    task automatic drain(input int unsigned budget);
        for (int g = 0; g < int'(budget); g++) begin
            if (!o_dout_valid && exp_bits.size() == 0) break;
            cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        end
        check_eq("drained", 32'(o_busy), 32'd0);
    endtask

    initial begin
        logic [L-1:0] w[3];
        logic [L-1:0] wd;
        int unsigned  nv;
        int unsigned  run;
        int unsigned  idx;
        int unsigned  acc;
        bit           started;
        bit           got2;

        i_rst = 1'b1; i_en = 1'b0; i_din_valid = 1'b0; iv_din = '0; i_ready = 1'b0;
        @(negedge i_clk);

        // Reset values, then ready rises on the first enabled edge
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        model_live = 1'b1;
        check_reset_outputs("rst");
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check_eq("ready_after_rst", 32'(o_ready), 32'd1);

        // Single word: latency, 24 contiguous bits, valid drops after the last
        cycle(1'b1, 1'b1, 24'hA5C3F0, 1'b1, 1'b0);
        check_eq("acc_ready", 32'(o_ready), 32'd0);
        check_eq("acc_valid", 32'(o_dout_valid), 32'd0);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        check_eq("lat_valid", 32'(o_dout_valid), 32'd1);
        check_eq("lat_bit0", 32'(o_dout), 32'd0);
        check_eq("lat_ready", 32'(o_ready), 32'd1);
        nv = 0;
        for (int g = 0; g < 40; g++) begin
            if (!o_dout_valid) break;
            nv++;
            cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        end
        check_eq("single_len", nv, 32'(L));

        // Back-to-back: three words, valid held high, no gap across 72 bits
        w[0] = 24'h000001; w[1] = 24'h800000; w[2] = 24'hFFFFFF;
        idx = 0; run = 0; started = 1'b0;
        for (int g = 0; g < 120; g++) begin
            if (o_dout_valid) begin
                run++;
                started = 1'b1;
            end else if (started) begin
                break;
            end
            cycle(1'b1, 1'(idx < 3), w[idx % 3], 1'b1, 1'b0);
            if (last_acc) idx++;
        end
        check_eq("b2b_words", idx, 32'd3);
        check_eq("b2b_run", run, 32'(3 * L));
        drain(10);

        // Backpressure at bit 7: output holds the stalled bit
        wd = 24'h123456;
        cycle(1'b1, 1'b1, wd, 1'b1, 1'b0);
        for (int g = 0; g < 40; g++) begin
            if (o_dout_valid && bit_pos == 7) break;
            cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        end
        for (int s = 0; s < 5; s++) begin
            cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
            check_eq("bp_dout", 32'(o_dout), 32'(wd[7]));
            check_eq("bp_valid", 32'(o_dout_valid), 32'd1);
            check_eq("bp_last", 32'(o_last), 32'd0);
        end
        drain(40);

        // Clock enable low mid-word: nothing consumed, nothing accepted
        wd = 24'h5A5A5A;
        cycle(1'b1, 1'b1, wd, 1'b1, 1'b0);
        for (int g = 0; g < 40; g++) begin
            if (o_dout_valid && bit_pos == 10) break;
            cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        end
        for (int s = 0; s < 3; s++) begin
            cycle(1'b0, 1'b1, 24'hFFFFFF, 1'b1, 1'b0);
            check_eq("en_dout", 32'(o_dout), 32'(wd[10]));
            check_eq("en_valid", 32'(o_dout_valid), 32'd1);
            check_eq("en_ready", 32'(o_ready), 32'd1);
            check_eq("en_last", 32'(o_last), 32'd0);
        end
        drain(40);

        // Reset at bit 10 with the buffer full discards both words
        cycle(1'b1, 1'b1, 24'h0F0F0F, 1'b1, 1'b0);
        got2 = 1'b0;
        for (int g = 0; g < 40; g++) begin
            if (got2 && o_dout_valid && bit_pos == 10) break;
            cycle(1'b1, !got2, 24'hABCDEF, 1'b1, 1'b0);
            if (last_acc) got2 = 1'b1;
        end
        check_eq("pre_rst_ready", 32'(o_ready), 32'd0);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
        check_reset_outputs("midrst");
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        check_eq("midrst_ready_up", 32'(o_ready), 32'd1);
        cycle(1'b1, 1'b1, 24'h3C96E1, 1'b1, 1'b0);
        drain(40);
        for (int s = 0; s < 5; s++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);

        // Random loopback: 1000 words with random valid, ready and enable
        n_words_out = 0;
        acc = 0;
        for (int c = 0; c < 80000; c++) begin
            if (acc >= 1000 && exp_bits.size() == 0) break;
            cycle(1'($urandom_range(9, 0) != 0),
                  1'(acc < 1000 && $urandom_range(3, 0) != 0),
                  L'($urandom),
                  1'($urandom_range(3, 0) != 0),
                  1'b0);
            if (last_acc) acc++;
        end
        check_eq("loop_words", n_words_out, 32'd1000);
        drain(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serializer_fsm.md
# serializer_fsm

Parallel-to-serial converter on the FIR output path: accepts LENGTH-bit words from the FIR filter through a valid/ready handshake and emits them one bit per transfer, LSB first, to the testbench or downstream link. It is the transmit-side counterpart of the FIR input deserializer and uses the same bit order and handshake semantics, so a serializer→deserializer loopback reproduces each word exactly. A one-word holding buffer lets back-to-back words stream with no idle bit between them.

## Interface
- LENGTH, 24, word width in bits; must be ≥ 2.
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  clock enable; when low, all registers hold and no handshake completes.
- iv_din  in  LENGTH  parallel word from the FIR.
- i_din_valid  in  1  iv_din valid.
- o_ready  out  1  holding buffer empty; a word is accepted when high.
- o_dout  out  1  serial data bit.
- o_dout_valid  out  1  o_dout valid.
- i_ready  in  1  downstream accepts the current bit.
- o_last  out  1  o_dout is bit LENGTH-1 of the current word.
- o_busy  out  1  shifter or buffer holds data.

## Operation
- Word accept: at an edge with i_en && i_din_valid && o_ready, iv_din is written to the buffer and buf_valid is set.
- Bit transfer: at an edge with i_en && o_dout_valid && i_ready.
- States: IDLE (shifter empty) and SHIFT (word in shifter). Encodings are local to the module.
- IDLE: if buf_valid, load shift_reg from the buffer, clear buf_valid, set bit_cnt=0, and go to SHIFT.
- SHIFT: o_dout = shift_reg[0] and o_dout_valid = 1.
  - On each non-final bit transfer: shift_reg right-shifts by 1 and bit_cnt increments.
  - On the transfer with bit_cnt == LENGTH-1:
    - if buf_valid, reload from the buffer and stay in SHIFT (no gap);
    - otherwise go to IDLE and drop o_dout_valid.
- Backpressure: while o_dout_valid && !i_ready, o_dout, o_last, bit_cnt and shift_reg hold.
- o_ready is registered and equals the next-state value of !buf_valid.
  - A word accepted on the same edge that the buffer drains into the shifter is impossible, because o_ready was low that cycle.
- o_last = (bit_cnt == LENGTH-1) && o_dout_valid.
- o_busy = buf_valid || (state == SHIFT).
- bit_cnt width is $clog2(LENGTH); it never exceeds LENGTH-1.
- Unused state encodings return to IDLE.

## Timing
- Reset values:
  - o_ready=0, o_dout=0, o_dout_valid=0, o_last=0, o_busy=0;
  - state=IDLE, buf_valid=0, bit_cnt=0, shift_reg=0.
- o_ready rises on the first enabled edge after i_rst deasserts.
- Latency: word accepted at edge k → bit 0 visible with o_dout_valid=1 after edge k+1.
- With i_ready held high, a word occupies exactly LENGTH consecutive cycles.
- Back-to-back streaming: sustained throughput is one word per LENGTH cycles.
  - o_ready re-asserts one cycle after each buffer→shifter load.
- Reset mid-word: the partial word and the buffered word are discarded, and o_dout_valid falls on the reset edge.
- i_en low:
  - outputs hold their values;
  - i_din_valid and i_ready are ignored, so no accept or transfer occurs;
  - operation resumes exactly where it stopped.

## Structure
- LENGTH default (24) lives in the shared FIR stream constants header, so it is common to the serializer, the deserializer and the FIR.
- State encodings stay local to the module.
- Single flat module, with no sub-module. The holding buffer is a single register plus a valid flag and does not justify its own block.

## Test plan
- Single word: accept 24'hA5C3F0 with i_ready=1 → 24 consecutive valid bits, LSB first: 0,0,0,0,1,1,1,1, 1,1,0,0,0,0,1,1, 1,0,1,0,0,1,0,1. o_last is high only on the 24th bit, then o_dout_valid falls.
- Back-to-back: present 24'h000001, 24'h800000 and 24'hFFFFFF with i_din_valid held high → 72 contiguous valid bits with no gap. Each o_ready low period lasts until the buffer drains.
- Backpressure: drop i_ready for 5 cycles at bit 7 of 24'h123456 → o_dout holds bit 7 (value 0) and bit_cnt is frozen; the stream resumes intact.
- Clock enable: pull i_en low for 3 cycles mid-word while i_ready=1 and i_din_valid=1 → no bits consumed and no word accepted; all outputs are frozen.
- Reset mid-operation: assert i_rst at bit 10 with the buffer full → the next cycle shows all outputs at their reset values. The first word after reset serializes correctly.
- Loopback: serializer feeding the deserializer, 1000 random words → every deserialized word equals its source, in order.
